// File: rtl/serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// serial_addsub_ctrl
//   Bit-serial adder/subtractor. One shared 1-bit full-adder slice evaluates
//   one operand bit per clock, LSB first. Subtraction is a + ~b + 1, so the
//   B bit is inverted and the carry chain starts at 1.
//
// Ports
//   clk        : clock, all state updates on rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request a new operation (sampled only in IDLE)
//   sub        : 0 = a+b, 1 = a-b (captured with start)
//   op_a, op_b : operands (captured with start)
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result/carry_out/overflow valid
//   result     : sum/difference modulo 2^WIDTH
//   carry_out  : carry out of MSB (subtract: 1 = no borrow)
//   overflow   : two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Shared 1-bit slice
    logic bit_a, bit_b, bit_s, bit_c;

    always_comb begin
        bit_a = a_q[cnt_q];
        bit_b = b_q[cnt_q] ^ sub_q;
        bit_s = bit_a ^ bit_b ^ carry_q;
        bit_c = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = sub;
                    cnt_d   = '0;
                    // +1 of the two's-complement negate enters as carry-in
                    carry_d = sub;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[cnt_q] = bit_s;
                carry_d      = bit_c;
                if (cnt_q == LAST_BIT) begin
                    // Carry into the MSB is carry_q; carry out is bit_c
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int   n_cmp;
    int   n_bad;
    int   done_cnt;
    exp_t sb_q[$];

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
        e.r  = full[W-1:0];
        e.co = full[W];
        if (s) e.ov = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        else   e.ov = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    // Launch one operation, scramble inputs after capture, wait (bounded) for done.
    // lat = index of the edge at which done is captured, counting the start edge as 0.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output int lat);
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        sb_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        sub   = 1'($urandom);
        lat = -1; r = '0; co = 1'b0; ov = 1'b0;
        for (int e = 1; e <= W + 6; e++) begin
            @(negedge clk);
            if (done) begin
                lat = e; r = result; co = carry_out; ov = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        #13;
        n_cmp++;
        if ({busy, done, result, carry_out, overflow} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b, required all 0",
                     busy, done, result, carry_out, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] va[5] = '{8'h05, 8'hFF, 8'h7F, 8'h03, 8'h80};
        logic [W-1:0] vb[5] = '{8'h03, 8'h01, 8'h01, 8'h05, 8'h01};
        logic         vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] vr[5] = '{8'h08, 8'h00, 8'h80, 8'hFE, 8'h7F};
        logic         vc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         vo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] r;
        logic         co, ov;
        int           lat;
        exp_t         e;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vs[i], r, co, ov, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (lat !== W + 1) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, W + 1);
            end
            n_cmp++;
            if ({r, co, ov} !== {vr[i], vc[i], vo[i]} || {r, co, ov} !== {e.r, e.co, e.ov}) begin
                n_bad++;
                $display("FAIL dir%0d_value: got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                         i, r, co, ov, vr[i], vc[i], vo[i]);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if ({result, carry_out, overflow} !== {vr[i], vc[i], vo[i]}) begin
                n_bad++;
                $display("FAIL dir%0d_hold: got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                         i, result, carry_out, overflow, vr[i], vc[i], vo[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int   lat;
        int   d0;
        exp_t e;
        logic [W-1:0] r;
        logic co, ov;
        d0 = done_cnt;
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; sub = 1'b0; start = 1'b1;
        sb_q.push_back(model(8'h12, 8'h34, 1'b0));
        @(posedge clk);
        #1; start = 1'b0;
        lat = -1; r = '0; co = 1'b0; ov = 1'b0;
        for (int e2 = 1; e2 <= W + 6; e2++) begin
            @(negedge clk);
            if (e2 == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_in_run: got %b required 1", busy);
                end
            end
            if (e2 == 3) begin
                op_a = 8'hF0; op_b = 8'h0F; sub = 1'b1; start = 1'b1;
            end
            if (e2 == 4) start = 1'b0;
            if (done && lat < 0) begin
                lat = e2; r = result; co = carry_out; ov = overflow;
            end
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (lat !== W + 1) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d required %0d", lat, W + 1);
        end
        n_cmp++;
        if ({r, co, ov} !== {e.r, e.co, e.ov}) begin
            n_bad++;
            $display("FAIL ignore_value: got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                     r, co, ov, e.r, e.co, e.ov);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL ignore_done_count: got %0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort;
        int   d0;
        int   lat;
        exp_t e;
        logic [W-1:0] r;
        logic co, ov;
        d0 = done_cnt;
        @(negedge clk);
        op_a = 8'h55; op_b = 8'h22; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, result, carry_out, overflow} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h co=%b ov=%b, required all 0",
                     busy, done, result, carry_out, overflow);
        end
        repeat (W + 3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (done_cnt !== d0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        do_op(8'hA5, 8'h3C, 1'b1, r, co, ov, lat);
        e = sb_q.pop_front();
        n_cmp++;
        if (lat !== W + 1 || {r, co, ov} !== {e.r, e.co, e.ov}) begin
            n_bad++;
            $display("FAIL after_abort: got lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
                     lat, r, co, ov, W + 1, e.r, e.co, e.ov);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ta[3] = '{8'h10, 8'hC8, 8'h64};
        logic [W-1:0] tb[3] = '{8'h20, 8'h64, 8'h9C};
        logic         ts[3] = '{1'b0, 1'b1, 1'b0};
        int   ndone;
        int   last_t;
        int   t;
        exp_t e;
        ndone = 0; last_t = -1; t = 0;
        @(negedge clk);
        op_a = ta[0]; op_b = tb[0]; sub = ts[0]; start = 1'b1;
        sb_q.push_back(model(ta[0], tb[0], ts[0]));
        while (ndone < 3 && t < 3 * (W + 2) + 10) begin
            @(negedge clk);
            t++;
            if (done) begin
                e = sb_q.pop_front();
                n_cmp++;
                if ({result, carry_out, overflow} !== {e.r, e.co, e.ov}) begin
                    n_bad++;
                    $display("FAIL b2b%0d_value: got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                             ndone, result, carry_out, overflow, e.r, e.co, e.ov);
                end
                if (last_t >= 0) begin
                    n_cmp++;
                    if (t - last_t !== W + 2) begin
                        n_bad++;
                        $display("FAIL b2b%0d_period: got %0d required %0d", ndone, t - last_t, W + 2);
                    end
                end
                last_t = t;
                ndone++;
                if (ndone < 3) begin
                    op_a = ta[ndone]; op_b = tb[ndone]; sub = ts[ndone];
                    sb_q.push_back(model(ta[ndone], tb[ndone], ts[ndone]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_cmp++;
        if (ndone !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d required 3", ndone);
        end
        sb_q.delete();
        repeat (W + 4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_stop: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, r;
        logic         s, co, ov;
        int           lat;
        exp_t         e;
        int           bad0;
        bad0 = n_bad;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            do_op(a, b, s, r, co, ov, lat);
            e = sb_q.pop_front();
            n_cmp++;
            if (lat !== W + 1 || {r, co, ov} !== {e.r, e.co, e.ov}) begin
                n_bad++;
                if (n_bad - bad0 <= 10)
                    $display("FAIL rand%0d a=%h b=%h sub=%b: got lat=%0d r=%h co=%b ov=%b required lat=%0d r=%h co=%b ov=%b",
                             i, a, b, s, lat, r, co, ov, W + 1, e.r, e.co, e.ov);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; done_cnt = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
